calc_exec_seq: RTL and testbench
================================

CALC_EXEC_SEQ -- requirements
Module: calc_exec_seq

Interface
REQ-001 SHALL have parameter NDIG, default 6, number of BCD digits per operand and result.
REQ-002 SHALL have port CLK_1K  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to evaluate num_a op num_b.
REQ-005 SHALL have port opcode  input  4  4'ha add, 4'hb sub, 4'hc mul, 4'hd div.
REQ-006 SHALL have port num_a  input  4*NDIG  BCD operand A, MS digit in the top nibble.
REQ-007 SHALL have port num_b  input  4*NDIG  BCD operand B, same format as num_a.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted through the done cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result, neg and err are valid in that cycle.
REQ-010 SHALL have port result  output  4*NDIG  BCD magnitude of the answer.
REQ-011 SHALL have port neg  output  1  sign of the answer; set only for sub when A<B.
REQ-012 SHALL have port err  output  1  overflow, divide-by-zero, bad opcode or non-BCD digit.

Function
REQ-013 SHALL use states IDLE, LOAD, EXEC, CONV and DONE.
REQ-014 IDLE: start=1 SHALL latch num_a, num_b and opcode, then go to LOAD; start in any other state SHALL be ignored.
REQ-015 LOAD: NDIG cycles, one digit of each operand per cycle, MS digit first; acc <= acc*10 + digit, where *10 = (acc<<3)+(acc<<1).
REQ-016 LOAD: any digit >9 SHALL set a sticky internal error bit.
REQ-017 EXEC, add/sub: 1 cycle; sub with A<B SHALL give magnitude B-A and neg=1.
REQ-018 EXEC, mul: 20-cycle shift-add into a 40-bit product.
REQ-019 EXEC, div: 20-cycle restoring divide; quotient truncated, remainder discarded.
REQ-020 EXEC length SHALL depend only on opcode, never on operand values or the error bit.
REQ-021 Opcode outside a..d SHALL set the error bit and use the 20-cycle EXEC.
REQ-022 After EXEC, binary result > 10^NDIG-1 SHALL set the error bit; divisor 0 SHALL set the error bit.
REQ-023 CONV: 20-cycle double-dabble binary-to-BCD, regardless of the error bit.
REQ-024 DONE: 1 cycle with done=1, then IDLE.
REQ-025 When the error bit is set, DONE SHALL present result=0, neg=0, err=1.
REQ-026 Latency (NDIG=6), counted from the edge sampling start: done high after edge 28 for add/sub, after edge 47 for all other opcodes.
REQ-027 result, neg and err SHALL hold their values until the next DONE.
REQ-028 An operand of all zeros SHALL be legal except as divisor; 0-0 SHALL give result 0 with neg=0.

Reset
REQ-029 RST low SHALL force IDLE at once and clear busy, done, result, neg, err, all latches and counters.
REQ-030 RST asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow.
REQ-031 A start pulse in the first cycle after RST release SHALL be accepted.

Structure
REQ-032 Package calc_pkg SHALL hold the opcode constants (OP_ADD..OP_DIV), the state encoding and the NDIG default.
REQ-033 Binary-to-BCD conversion SHALL be a sub-module bin2bcd_seq with start/done handshake, instantiated once; everything else stays in calc_exec_seq.

Verification
REQ-034 num_a=000123, num_b=000456, op a -> after 28 cycles: done=1, result=000579, neg=0, err=0.
REQ-035 num_a=000005, num_b=000012, op b -> result=000007, neg=1, err=0.
REQ-036 000999 mul 001001 -> result=999999, err=0 at 47 cycles; 001000 mul 001000 -> result=000000, err=1.
REQ-037 999999 div 000007 -> result=142857; 000100 div 000000 -> err=1, result=0; both done at 47 cycles.
REQ-038 A second start 5 cycles into an operation -> ignored, exactly one done pulse.
REQ-039 RST pulsed at cycle 10 of a mul -> busy=0 at once, no done pulse; a new add then completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the BCD calculator core.
//   OP_*      opcode encodings accepted on calc_exec_seq.opcode
//   state_t   control FSM encoding
//   BIN_W     binary datapath width; 20 bits holds 999999, so NDIG <= 6
package calc_pkg;
  localparam int NDIG_DEF = 6;
  localparam int BIN_W    = 20;
  localparam int PROD_W   = 2 * BIN_W;
  localparam int EXEC_CYC = 20;
  localparam int CNT_W    = 5;

  localparam logic [3:0] OP_ADD = 4'ha;
  localparam logic [3:0] OP_SUB = 4'hb;
  localparam logic [3:0] OP_MUL = 4'hc;
  localparam logic [3:0] OP_DIV = 4'hd;

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CONV, DONE} state_t;

  // add/sub finish EXEC in a single cycle; everything else takes EXEC_CYC
  function automatic logic is_short_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_valid_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_DIV);
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, BW cycles.
//   CLK_1K, RST  clock / async active-low reset
//   i_start      one-cycle pulse, latches i_bin
//   o_done       one-cycle pulse when o_bcd is final
//   o_bcd        NDIG BCD digits, MS digit in the top nibble
//   o_ovf        value did not fit in NDIG digits
module bin2bcd_seq import calc_pkg::*; #(
  parameter int NDIG = NDIG_DEF,
  parameter int BW   = BIN_W
) (
  input  logic              CLK_1K,
  input  logic              RST,
  input  logic              i_start,
  input  logic [BW-1:0]     i_bin,
  output logic              o_done,
  output logic [4*NDIG-1:0] o_bcd,
  output logic              o_ovf
);
  localparam int CW = $clog2(BW + 1);

  logic [BW-1:0]     r_bin;
  logic [4*NDIG-1:0] r_bcd;
  logic [CW-1:0]     r_cnt;
  logic              r_busy, r_done, r_ovf;
  logic [4*NDIG-1:0] w_adj;

  // add-3 to every digit >= 5 before the shift
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                       : r_bcd[4*g +: 4];
  end

  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_bin  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
        r_ovf  <= 1'b0;
      end else if (r_busy) begin
        r_bcd <= {w_adj[4*NDIG-2:0], r_bin[BW-1]};
        r_bin <= r_bin << 1;
        // a bit shifted out of the top digit means the value needs NDIG+1 digits
        r_ovf <= r_ovf | w_adj[4*NDIG-1];
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(BW - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_bcd;
  assign o_ovf  = r_ovf;
endmodule

// File: rtl/calc_exec_seq.sv
// calc_exec_seq: sequential BCD calculator (add/sub/mul/div).
//   CLK_1K, RST      clock / async active-low reset
//   start            request; accepted only in IDLE
//   opcode           a add, b sub, c mul, d div
//   num_a, num_b     BCD operands, MS digit on top
//   busy             high from the cycle after start through DONE
//   done             one-cycle pulse; result/neg/err valid and held until next done
//   result, neg, err BCD magnitude, sign (sub only), error flag
// Flow: LOAD folds digits into binary, EXEC computes, CONV converts back.
module calc_exec_seq import calc_pkg::*; #(
  parameter int NDIG = NDIG_DEF
) (
  input  logic              CLK_1K,
  input  logic              RST,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [4*NDIG-1:0] num_a,
  input  logic [4*NDIG-1:0] num_b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              neg,
  output logic              err
);
  localparam logic [PROD_W-1:0] MAXV = PROD_W'(10**NDIG - 1);

  state_t              r_state, w_state_nxt;
  logic [4*NDIG-1:0]   r_a, r_b, r_result;
  logic [3:0]          r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    r_acc_a, r_acc_b, r_mplier, r_quot, r_rem;
  logic [PROD_W-1:0]   r_mcand, r_prod;
  logic                r_err, r_neg_q, r_neg_o, r_err_o;

  logic [3:0]          w_dig_a, w_dig_b;
  logic [BIN_W-1:0]    w_acc_a_nxt, w_acc_b_nxt, w_quot_nxt, w_rem_nxt, w_diff;
  logic [BIN_W:0]      w_shift;
  logic [PROD_W-1:0]   w_prod_nxt, w_exec_res;
  logic                w_bad_dig, w_ge, w_exec_last, w_ovf, w_div0, w_conv_start;
  logic                w_bcd_done, w_bcd_ovf;
  logic [4*NDIG-1:0]   w_bcd;

  // LOAD: acc*10 + digit, *10 as (acc<<3)+(acc<<1)
  assign w_dig_a     = r_a[4*NDIG-1 -: 4];
  assign w_dig_b     = r_b[4*NDIG-1 -: 4];
  assign w_acc_a_nxt = (r_acc_a << 3) + (r_acc_a << 1) + BIN_W'(w_dig_a);
  assign w_acc_b_nxt = (r_acc_b << 3) + (r_acc_b << 1) + BIN_W'(w_dig_b);
  assign w_bad_dig   = (w_dig_a > 4'd9) || (w_dig_b > 4'd9);

  // EXEC: shift-add multiply and restoring divide, one step per cycle
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_shift    = {r_rem, r_quot[BIN_W-1]};
  assign w_ge       = w_shift >= {1'b0, r_acc_b};
  // true difference is < divisor, so the 20-bit wrap is exact
  assign w_diff     = w_shift[BIN_W-1:0] - r_acc_b;
  assign w_rem_nxt  = w_ge ? w_diff : w_shift[BIN_W-1:0];
  assign w_quot_nxt = {r_quot[BIN_W-2:0], w_ge};

  // value handed to the converter on the last EXEC cycle
  always_comb begin
    w_exec_res = '0;
    case (r_op)
      OP_ADD:  w_exec_res = PROD_W'(r_acc_a) + PROD_W'(r_acc_b);
      OP_SUB:  w_exec_res = (r_acc_a >= r_acc_b) ? PROD_W'(r_acc_a - r_acc_b)
                                                 : PROD_W'(r_acc_b - r_acc_a);
      OP_MUL:  w_exec_res = w_prod_nxt;
      OP_DIV:  w_exec_res = PROD_W'(w_quot_nxt);
      default: w_exec_res = '0;
    endcase
  end

  assign w_ovf        = w_exec_res > MAXV;
  assign w_div0       = (r_op == OP_DIV) && (r_acc_b == '0);
  // EXEC length depends on opcode only, never on operands or error state
  assign w_exec_last  = is_short_op(r_op) || (r_cnt == CNT_W'(EXEC_CYC - 1));
  assign w_conv_start = (r_state == EXEC) && w_exec_last;

  bin2bcd_seq #(.NDIG(NDIG), .BW(BIN_W)) u_b2b (
    .CLK_1K (CLK_1K),
    .RST    (RST),
    .i_start(w_conv_start),
    .i_bin  (w_exec_res[BIN_W-1:0]),
    .o_done (w_bcd_done),
    .o_bcd  (w_bcd),
    .o_ovf  (w_bcd_ovf)
  );

  // FSM: state register
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    if (r_cnt == CNT_W'(NDIG - 1)) w_state_nxt = EXEC;
      EXEC:    if (w_exec_last) w_state_nxt = CONV;
      CONV:    if (w_bcd_done) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (r_state != IDLE) busy = 1'b1;
    if (r_state == DONE) done = 1'b1;
  end

  // datapath
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc_a  <= '0;
      r_acc_b  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_result <= '0;
      r_neg_o  <= 1'b0;
      r_err_o  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= num_a;
          r_b     <= num_b;
          r_op    <= opcode;
          r_cnt   <= '0;
          r_acc_a <= '0;
          r_acc_b <= '0;
          r_err   <= 1'b0;
          r_neg_q <= 1'b0;
        end
        LOAD: begin
          r_acc_a <= w_acc_a_nxt;
          r_acc_b <= w_acc_b_nxt;
          r_a     <= {r_a[4*NDIG-5:0], 4'h0};
          r_b     <= {r_b[4*NDIG-5:0], 4'h0};
          if (w_bad_dig) r_err <= 1'b1;
          if (r_cnt == CNT_W'(NDIG - 1)) begin
            r_cnt    <= '0;
            r_mcand  <= PROD_W'(w_acc_a_nxt);
            r_mplier <= w_acc_b_nxt;
            r_prod   <= '0;
            r_quot   <= w_acc_a_nxt;
            r_rem    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        EXEC: begin
          r_cnt    <= r_cnt + 1'b1;
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_quot   <= w_quot_nxt;
          r_rem    <= w_rem_nxt;
          if (w_exec_last) begin
            r_err   <= r_err | w_ovf | w_div0 | ~is_valid_op(r_op);
            r_neg_q <= (r_op == OP_SUB) && (r_acc_a < r_acc_b);
          end
        end
        CONV: if (w_bcd_done) begin
          r_result <= (r_err | w_bcd_ovf) ? '0 : w_bcd;
          r_neg_o  <= r_neg_q & ~(r_err | w_bcd_ovf);
          r_err_o  <= r_err | w_bcd_ovf;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign neg    = r_neg_o;
  assign err    = r_err_o;
endmodule

// File: tb/tb_calc_exec_seq.sv
module tb_calc_exec_seq;
  logic        CLK_1K = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [23:0] num_a = '0, num_b = '0;
  logic        busy, done, neg, err;
  logic [23:0] result;

  int total = 0;
  int bad = 0;

  always #5 CLK_1K = ~CLK_1K;

  calc_exec_seq #(.NDIG(6)) dut (
    .CLK_1K(CLK_1K), .RST(RST), .start(start), .opcode(opcode),
    .num_a(num_a), .num_b(num_b), .busy(busy), .done(done),
    .result(result), .neg(neg), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] to_bcd(input longint v);
    logic [23:0] r;
    longint t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // reference: decimal arithmetic straight from the operand digits
  function automatic void model(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                                output logic [23:0] r, output logic n, output logic e,
                                output int lat);
    longint va, vb, v;
    logic [3:0] da, db;
    va = 0; vb = 0; v = 0; e = 1'b0; n = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da > 9 || db > 9) e = 1'b1;
      va = va * 10 + longint'(da);
      vb = vb * 10 + longint'(db);
    end
    lat = (op == 4'ha || op == 4'hb) ? 28 : 47;
    case (op)
      4'ha: v = va + vb;
      4'hb: if (va >= vb) v = va - vb; else begin v = vb - va; n = 1'b1; end
      4'hc: v = va * vb;
      4'hd: if (vb == 0) e = 1'b1; else v = va / vb;
      default: e = 1'b1;
    endcase
    if (v > 999999) e = 1'b1;
    if (e) begin v = 0; n = 1'b0; end
    r = to_bcd(v);
  endfunction

  // drive one request and wait (bounded) for done; lat=-1 on timeout
  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                       output int lat, output logic [23:0] r, output logic n, output logic e);
    int w;
    w = 0;
    @(negedge CLK_1K);
    while (busy && w < 100) begin @(negedge CLK_1K); w++; end
    num_a = a; num_b = b; opcode = op; start = 1'b1;
    @(posedge CLK_1K); #1 start = 1'b0;
    lat = -1; r = '0; n = 1'b0; e = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(posedge CLK_1K); #1;
      if (done) begin lat = k; r = result; n = neg; e = err; break; end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK_1K);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (result !== 24'h0) begin bad++; $display("FAIL reset result: got %h want 000000", result); end
    total++; if (neg !== 1'b0) begin bad++; $display("FAIL reset neg: got %b want 0", neg); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", err); end
    @(negedge CLK_1K); RST = 1'b1;
  endtask

  task automatic test_directed();
    logic [23:0] ta[11], tb[11], tr[11];
    logic [3:0]  to[11];
    logic        tn[11], te[11];
    int          tl[11];
    int lat; logic [23:0] r; logic n, e;
    ta[0]=24'h000123; tb[0]=24'h000456; to[0]=4'ha; tr[0]=24'h000579; tn[0]=0; te[0]=0; tl[0]=28;
    ta[1]=24'h000005; tb[1]=24'h000012; to[1]=4'hb; tr[1]=24'h000007; tn[1]=1; te[1]=0; tl[1]=28;
    ta[2]=24'h000999; tb[2]=24'h001001; to[2]=4'hc; tr[2]=24'h999999; tn[2]=0; te[2]=0; tl[2]=47;
    ta[3]=24'h001000; tb[3]=24'h001000; to[3]=4'hc; tr[3]=24'h000000; tn[3]=0; te[3]=1; tl[3]=47;
    ta[4]=24'h999999; tb[4]=24'h000007; to[4]=4'hd; tr[4]=24'h142857; tn[4]=0; te[4]=0; tl[4]=47;
    ta[5]=24'h000100; tb[5]=24'h000000; to[5]=4'hd; tr[5]=24'h000000; tn[5]=0; te[5]=1; tl[5]=47;
    ta[6]=24'h000000; tb[6]=24'h000000; to[6]=4'hb; tr[6]=24'h000000; tn[6]=0; te[6]=0; tl[6]=28;
    ta[7]=24'h999999; tb[7]=24'h000001; to[7]=4'ha; tr[7]=24'h000000; tn[7]=0; te[7]=1; tl[7]=28;
    ta[8]=24'h000123; tb[8]=24'h000001; to[8]=4'he; tr[8]=24'h000000; tn[8]=0; te[8]=1; tl[8]=47;
    ta[9]=24'h00012a; tb[9]=24'h000001; to[9]=4'ha; tr[9]=24'h000000; tn[9]=0; te[9]=1; tl[9]=28;
    ta[10]=24'h000000; tb[10]=24'h000005; to[10]=4'hd; tr[10]=24'h000000; tn[10]=0; te[10]=0; tl[10]=47;
    for (int i = 0; i < 11; i++) begin
      do_op(ta[i], tb[i], to[i], lat, r, n, e);
      total++; if (lat != tl[i]) begin bad++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, tl[i]); end
      total++; if (r !== tr[i]) begin bad++; $display("FAIL directed[%0d] result: got %h want %h", i, r, tr[i]); end
      total++; if (n !== tn[i]) begin bad++; $display("FAIL directed[%0d] neg: got %b want %b", i, n, tn[i]); end
      total++; if (e !== te[i]) begin bad++; $display("FAIL directed[%0d] err: got %b want %b", i, e, te[i]); end
    end
  endtask

  function automatic logic [23:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return to_bcd(longint'($urandom_range(0, 999999)));
      1:       return to_bcd(longint'($urandom_range(0, 999)));
      2:       return to_bcd(longint'($urandom_range(0, 9)));
      default: return to_bcd(longint'($urandom_range(0, 2000)));
    endcase
  endfunction

  task automatic test_random();
    logic [23:0] a, b, xr, r;
    logic [3:0]  op;
    logic        xn, xe, n, e;
    int          xl, lat, p;
    for (int it = 0; it < 40; it++) begin
      a = rand_operand();
      b = rand_operand();
      case ($urandom_range(0, 9))
        0, 1, 9: op = 4'ha;
        2, 3:    op = 4'hb;
        4, 5:    op = 4'hc;
        6, 7:    op = 4'hd;
        default: op = 4'($urandom_range(0, 9));
      endcase
      if ($urandom_range(0, 7) == 0) begin
        p = $urandom_range(0, 5);
        if ($urandom_range(0, 1) == 0) a[4*p +: 4] = 4'($urandom_range(10, 15));
        else                           b[4*p +: 4] = 4'($urandom_range(10, 15));
      end
      model(a, b, op, xr, xn, xe, xl);
      do_op(a, b, op, lat, r, n, e);
      total++; if (lat != xl) begin bad++; $display("FAIL random[%0d] latency %h op%h %h: got %0d want %0d", it, a, op, b, lat, xl); end
      total++; if (r !== xr) begin bad++; $display("FAIL random[%0d] result %h op%h %h: got %h want %h", it, a, op, b, r, xr); end
      total++; if (n !== xn) begin bad++; $display("FAIL random[%0d] neg %h op%h %h: got %b want %b", it, a, op, b, n, xn); end
      total++; if (e !== xe) begin bad++; $display("FAIL random[%0d] err %h op%h %h: got %b want %b", it, a, op, b, e, xe); end
    end
  endtask

  task automatic test_hold();
    int lat; logic [23:0] r; logic n, e;
    do_op(24'h000321, 24'h000654, 4'hb, lat, r, n, e);
    total++; if (r !== 24'h000333 || n !== 1'b1) begin bad++; $display("FAIL hold setup: got %h neg %b want 000333 neg 1", r, n); end
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK_1K); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL hold done[%0d]: got %b want 0", k, done); end
      total++; if (result !== 24'h000333 || neg !== 1'b1 || err !== 1'b0) begin
        bad++; $display("FAIL hold outputs[%0d]: got %h/%b/%b want 000333/1/0", k, result, neg, err);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int ndone, lat;
    logic [23:0] r;
    @(negedge CLK_1K);
    num_a = 24'h000123; num_b = 24'h000456; opcode = 4'ha; start = 1'b1;
    @(posedge CLK_1K); #1 start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b busy after start: got %b want 1", busy); end
    ndone = 0; lat = -1; r = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge CLK_1K); #1;
      if (k == 5) begin start = 1'b0; num_a = 24'h000123; num_b = 24'h000456; opcode = 4'ha; end
      if (done) begin ndone++; if (lat < 0) begin lat = k; r = result; end end
      if (k == 4) begin
        @(negedge CLK_1K);
        num_a = 24'h999999; num_b = 24'h999999; opcode = 4'hc; start = 1'b1;
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL b2b done pulses: got %0d want 1", ndone); end
    total++; if (lat != 28) begin bad++; $display("FAIL b2b latency: got %0d want 28", lat); end
    total++; if (r !== 24'h000579) begin bad++; $display("FAIL b2b result: got %h want 000579", r); end
  endtask

  task automatic test_reset_mid();
    int ndone, nbusy, lat;
    logic [23:0] r;
    @(negedge CLK_1K);
    num_a = 24'h000999; num_b = 24'h001001; opcode = 4'hc; start = 1'b1;
    @(posedge CLK_1K); #1 start = 1'b0;
    repeat (10) @(posedge CLK_1K);
    #2 RST = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset done: got %b want 0", done); end
    total++; if (result !== 24'h0 || err !== 1'b0 || neg !== 1'b0) begin
      bad++; $display("FAIL midreset outputs: got %h/%b/%b want 000000/0/0", result, neg, err);
    end
    @(negedge CLK_1K); RST = 1'b1;
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge CLK_1K); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL midreset stray done: got %0d want 0", ndone); end
    total++; if (nbusy != 0) begin bad++; $display("FAIL midreset stray busy cycles: got %0d want 0", nbusy); end
    // start in the very first cycle after release
    @(negedge CLK_1K); RST = 1'b0;
    @(negedge CLK_1K); RST = 1'b1;
    num_a = 24'h000123; num_b = 24'h000456; opcode = 4'ha; start = 1'b1;
    @(posedge CLK_1K); #1 start = 1'b0;
    lat = -1; r = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge CLK_1K); #1;
      if (done) begin lat = k; r = result; break; end
    end
    total++; if (lat != 28) begin bad++; $display("FAIL post-reset latency: got %0d want 28", lat); end
    total++; if (r !== 24'h000579) begin bad++; $display("FAIL post-reset result: got %h want 000579", r); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
